// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  // Default maximum pattern length and match counter width.
  localparam int PAT_W_DEF = 5;
  localparam int CNT_W_DEF = 8;

  // Preset for the classic framing marker, first-received bit at the MSB.
  localparam logic [4:0] PAT_00101 = 5'b00101;

  // Clamp a requested pattern length to the physical history depth.
  function automatic int min_len(input int len, input int pat_w);
    return (len > pat_w) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register, fill counter and masked compare.
// Produces match_next: the value the registered out pulse takes on the next edge.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             clr,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic             ovl,
  output logic             match_next
);

  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] mask;

  // Post-shift history, saturating fill, compare mask and match decision.
  // A clr cycle (configuration load) discards any bit offered in that cycle.
  always_comb begin
    hist_shift = (hist << 1) | PAT_W'(in);
    fill_inc   = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    mask       = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    match_next = in_valid && !clr && (len != '0) && (fill_inc >= len) &&
                 (((hist_shift ^ pat) & mask) == '0);
  end

  // Shift in valid bits; a non-overlapping match restarts the fill count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (in_valid) begin
      hist <= hist_shift;
      fill <= (match_next && !ovl) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial sequence detector (top level).
// Optional feature: define SEQ_DET_CNT_EN to build the saturating match_cnt
// output; without it cnt_clr is accepted and ignored.
// Stream handshake: in is consumed on every rising edge where in_valid is high
// and cfg_load is low; there is no backpressure, the stream is never stalled.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
`ifdef SEQ_DET_CNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             out
);

  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             ovl;
  logic             match_next;

  // Latch configuration; len = 0 after reset keeps the detector idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat <= '0;
      len <= '0;
      ovl <= 1'b1;
    end else if (cfg_load) begin
      pat <= cfg_pattern;
      len <= LEN_W'(min_len(int'(cfg_len), PAT_W));
      ovl <= cfg_overlap;
    end
  end

  seq_det_hist #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_hist (
    .clk        (clk),
    .reset_n    (reset_n),
    .in         (in),
    .in_valid   (in_valid),
    .clr        (cfg_load),
    .pat        (pat),
    .len        (len),
    .ovl        (ovl),
    .match_next (match_next)
  );

  // Registered one-cycle match pulse, cleared by a configuration load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out <= 1'b0;
    end else if (cfg_load) begin
      out <= 1'b0;
    end else begin
      out <= match_next;
    end
  end

`ifdef SEQ_DET_CNT_EN
  // Saturating match counter; a clear beats a simultaneous match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (match_next && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  // Counter not built: cnt_clr is intentionally left without effect.
  logic [CNT_W:0] unused_cnt;
  assign unused_cnt = {(CNT_W + 1){cnt_clr}};
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed testbench for seq_det_prog (PAT_W = 5, CNT_W = 2).
// Counter checks are compiled in only when SEQ_DET_CNT_EN is defined.
module tb_seq_det_prog;
  import seq_det_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       in;
  logic       in_valid;
  logic       cfg_load;
  logic [4:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       out;
`ifdef SEQ_DET_CNT_EN
  logic [1:0] match_cnt;
`endif

  int vecs;
  int errs;

  seq_det_prog #(
    .PAT_W (5),
    .CNT_W (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in          (in),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
`ifdef SEQ_DET_CNT_EN
    .match_cnt   (match_cnt),
`endif
    .out         (out)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic drive_bit(input logic b);
    in       = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [4:0] p, input logic [2:0] l, input logic o);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (out !== 1'b0) begin
      errs++;
      $display("FAIL reset_out got=%b want=0", out);
    end
`ifdef SEQ_DET_CNT_EN
    vecs++;
    if (match_cnt !== 2'd0) begin
      errs++;
      $display("FAIL reset_cnt got=%0d want=0", match_cnt);
    end
`endif
    reset_n = 1'b1;
    // Unconfigured (len 0): no pulse on any stream.
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1);
      vecs++;
      if (out !== 1'b0) begin
        errs++;
        $display("FAIL unconfigured bit%0d got=%b want=0", i, out);
      end
    end
  endtask

  task automatic test_basic_00101();
    logic [17:0] s;
    logic [17:0] e;
    s = 18'b110010110000010111;
    e = 18'b000000100000000100;
    clear_cnt();
    load_cfg(PAT_00101, 3'd5, 1'b1);
    for (int i = 17; i >= 0; i--) begin
      drive_bit(s[i]);
      vecs++;
      if (out !== e[i]) begin
        errs++;
        $display("FAIL basic bit%0d got=%b want=%b", 18 - i, out, e[i]);
      end
    end
`ifdef SEQ_DET_CNT_EN
    vecs++;
    if (match_cnt !== 2'd2) begin
      errs++;
      $display("FAIL basic_cnt got=%0d want=2", match_cnt);
    end
`endif
  endtask

  task automatic test_overlap_modes();
    logic [4:0] s;
    logic [4:0] e1;
    logic [4:0] e0;
    s  = 5'b10101;
    e1 = 5'b00101;
    e0 = 5'b00100;
    clear_cnt();
    load_cfg(5'b00101, 3'd3, 1'b1);
    for (int i = 4; i >= 0; i--) begin
      drive_bit(s[i]);
      vecs++;
      if (out !== e1[i]) begin
        errs++;
        $display("FAIL ovl1 bit%0d got=%b want=%b", 5 - i, out, e1[i]);
      end
    end
`ifdef SEQ_DET_CNT_EN
    vecs++;
    if (match_cnt !== 2'd2) begin
      errs++;
      $display("FAIL ovl1_cnt got=%0d want=2", match_cnt);
    end
`endif
    clear_cnt();
    load_cfg(5'b00101, 3'd3, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      drive_bit(s[i]);
      vecs++;
      if (out !== e0[i]) begin
        errs++;
        $display("FAIL ovl0 bit%0d got=%b want=%b", 5 - i, out, e0[i]);
      end
    end
`ifdef SEQ_DET_CNT_EN
    vecs++;
    if (match_cnt !== 2'd1) begin
      errs++;
      $display("FAIL ovl0_cnt got=%0d want=1", match_cnt);
    end
`endif
    // Single-bit pattern, overlapping: consecutive pulses are legal.
    s  = 5'b00111;
    e1 = 5'b00111;
    load_cfg(5'b00001, 3'd1, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      drive_bit(s[i]);
      vecs++;
      if (out !== e1[i]) begin
        errs++;
        $display("FAIL len1 bit%0d got=%b want=%b", 3 - i, out, e1[i]);
      end
    end
  endtask

  task automatic test_valid_gap();
    logic [4:0] s;
    s = 5'b00101;
    load_cfg(PAT_00101, 3'd5, 1'b1);
    for (int i = 4; i >= 2; i--) begin
      drive_bit(s[i]);
      vecs++;
      if (out !== 1'b0) begin
        errs++;
        $display("FAIL gap_pre bit%0d got=%b want=0", 5 - i, out);
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      vecs++;
      if (out !== 1'b0) begin
        errs++;
        $display("FAIL gap_idle cyc%0d got=%b want=0", i, out);
      end
    end
    drive_bit(s[1]);
    vecs++;
    if (out !== 1'b0) begin
      errs++;
      $display("FAIL gap_bit4 got=%b want=0", out);
    end
    drive_bit(s[0]);
    vecs++;
    if (out !== 1'b1) begin
      errs++;
      $display("FAIL gap_bit5 got=%b want=1", out);
    end
    idle_cycle();
    vecs++;
    if (out !== 1'b0) begin
      errs++;
      $display("FAIL gap_after got=%b want=0", out);
    end
  endtask

  task automatic test_reload();
    logic [3:0] pre;
    logic [5:0] s;
    logic [5:0] e;
    pre = 4'b0010;
    s   = 6'b100101;
    e   = 6'b000001;
    load_cfg(PAT_00101, 3'd5, 1'b1);
    for (int i = 3; i >= 0; i--) drive_bit(pre[i]);
    load_cfg(PAT_00101, 3'd5, 1'b1);
    for (int i = 5; i >= 0; i--) begin
      drive_bit(s[i]);
      vecs++;
      if (out !== e[i]) begin
        errs++;
        $display("FAIL reload bit%0d got=%b want=%b", 6 - i, out, e[i]);
      end
    end
  endtask

  task automatic test_len_clamp();
    logic [6:0] s;
    logic [6:0] e;
    s = 7'b1100101;
    e = 7'b0000001;
    load_cfg(PAT_00101, 3'd7, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      drive_bit(s[i]);
      vecs++;
      if (out !== e[i]) begin
        errs++;
        $display("FAIL clamp bit%0d got=%b want=%b", 7 - i, out, e[i]);
      end
    end
    load_cfg(PAT_00101, 3'd0, 1'b1);
    s = 7'b0010111;
    for (int i = 6; i >= 0; i--) begin
      drive_bit(s[i]);
      vecs++;
      if (out !== 1'b0) begin
        errs++;
        $display("FAIL len0 bit%0d got=%b want=0", 7 - i, out);
      end
    end
  endtask

`ifdef SEQ_DET_CNT_EN
  task automatic test_counter();
    logic [1:0] exp_cnt [4];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
    clear_cnt();
    load_cfg(5'b00001, 3'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1);
      vecs++;
      if (match_cnt !== exp_cnt[i]) begin
        errs++;
        $display("FAIL cnt_sat m%0d got=%0d want=%0d", i + 1, match_cnt, exp_cnt[i]);
      end
    end
    cnt_clr = 1'b1;
    drive_bit(1'b1);
    cnt_clr = 1'b0;
    vecs++;
    if (match_cnt !== 2'd0 || out !== 1'b1) begin
      errs++;
      $display("FAIL cnt_clr_prio got=cnt%0d/out%b want=cnt0/out1", match_cnt, out);
    end
  endtask
`endif

  task automatic test_reset_midstream();
    load_cfg(5'b00001, 3'd1, 1'b1);
    drive_bit(1'b1);
    vecs++;
    if (out !== 1'b1) begin
      errs++;
      $display("FAIL mid_pre got=%b want=1", out);
    end
    reset_n = 1'b0;
    #1;
    vecs++;
    if (out !== 1'b0) begin
      errs++;
      $display("FAIL mid_async_out got=%b want=0", out);
    end
`ifdef SEQ_DET_CNT_EN
    vecs++;
    if (match_cnt !== 2'd0) begin
      errs++;
      $display("FAIL mid_async_cnt got=%0d want=0", match_cnt);
    end
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    // Configuration was wiped (len 0): a stream of ones must not match.
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b1);
      vecs++;
      if (out !== 1'b0) begin
        errs++;
        $display("FAIL mid_post bit%0d got=%b want=0", i, out);
      end
    end
  endtask

  initial begin
    vecs        = 0;
    errs        = 0;
    reset_n     = 1'b0;
    in          = 1'b0;
    in_valid    = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b1;
    cnt_clr     = 1'b0;
    #1;
    test_reset();
    test_basic_00101();
    test_overlap_modes();
    test_valid_gap();
    test_reload();
    test_len_clamp();
`ifdef SEQ_DET_CNT_EN
    test_counter();
`endif
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Runtime-programmable serial sequence detector. It is the parametrised successor to the fixed "00101" detector. It watches a 1-bit serial stream qualified by `in_valid` and matches against a pattern of 1 to `PAT_W` bits, loaded at run time. Matching runs in overlapping or non-overlapping mode. It emits a registered one-cycle `out` pulse per match and, optionally, keeps a saturating match count. It sits between a serial front end and the control logic that reacts to framing or marker sequences.

## Interface
- `PAT_W`, 5, maximum pattern length in bits (≥1).
- `CNT_W`, 8, match counter width (used only with `SEQ_DET_CNT_EN`).
- `LEN_W`, `$clog2(PAT_W+1)`, width of the length fields (derived; do not override).
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in`  input  1  serial data bit.
- `in_valid`  input  1  `in` is sampled only when high.
- `cfg_load`  input  1  one-cycle strobe that latches `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`  input  `PAT_W`  pattern, LSB-aligned. The first-received bit is `cfg_pattern[cfg_len-1]`; the last is `cfg_pattern[0]`.
- `cfg_len`  input  `LEN_W`  pattern length.
- `cfg_overlap`  input  1  1 = overlapping matches, 0 = non-overlapping.
- `cnt_clr`  input  1  synchronous clear of `match_cnt`.
- `out`  output  1  registered match pulse.
- `match_cnt`  output  `CNT_W`  matches since the last reset or clear; present only with `SEQ_DET_CNT_EN`.

## Operation
- State:
  - `hist[PAT_W-1:0]`: shift register of received bits, newest bit at bit 0.
  - `fill[LEN_W-1:0]`: count of valid history bits, saturating at `PAT_W`.
  - Latched `pat`, `len`, `ovl`.
- Reset values:
  - `hist`, `fill`, `out`, `match_cnt` = 0.
  - `pat` = 0, `len` = 0, `ovl` = 1.
  - With `len` = 0 the block never matches until configured.
- `cfg_load` high:
  - Latch the configuration.
  - Clear `hist`, `fill` and `out`.
  - Discard any `in_valid` bit in that same cycle (`cfg_load` wins).
  - Leave `match_cnt` unchanged.
- Length clamping: if `cfg_len` > `PAT_W`, latch `len` = `PAT_W`. If `cfg_len` = 0, matching is disabled.
- On each `in_valid` cycle without `cfg_load`:
  - Shift: `hist <= {hist[PAT_W-2:0], in}`.
  - Update `fill <= min(fill+1, PAT_W)`.
- Match condition, evaluated on the post-shift history:
  - `len` ≠ 0, and
  - `fill_next` ≥ `len`, and
  - the low `len` bits of the shifted history equal the low `len` bits of `pat`.
- On a match:
  - Set `out` to 1 for exactly one cycle.
  - If `ovl` = 0, set `fill` to 0 so that no bit of the matched sequence is reused.
  - If `ovl` = 1, `fill` keeps counting normally.
- No `in_valid`: `hist` and `fill` hold and `out` = 0. Gaps in `in_valid` do not break a partial sequence.
- `match_cnt`:
  - Increments on each match and saturates at all-ones.
  - `cnt_clr` has priority over a simultaneous match; the result is 0.

## Timing
- Latency: `out` rises on the clock edge that samples the final pattern bit, so it is visible in the following cycle. It is a registered Moore-style output.
- `out` never stays high for two consecutive cycles unless two consecutive valid bits each complete a match (overlapping mode, e.g. pattern "1", len 1).
- `match_cnt` updates on the same edge as `out`.
- Configuration takes effect on the first valid bit after the `cfg_load` cycle.
- Asserting `reset_n` low mid-stream clears all state immediately, including the latched configuration.

## Configuration
- `SEQ_DET_CNT_EN` defined:
  - The `match_cnt` port and the saturating counter are built.
  - `cnt_clr` is functional.
- `SEQ_DET_CNT_EN` undefined:
  - There is no `match_cnt` port and no counter logic.
  - `cnt_clr` is still present but ignored.
  - `out` behaviour is identical in both builds.

## Structure
- Package `seq_det_pkg` holds:
  - the default `PAT_W` / `CNT_W` constants;
  - a function `min_len(len, PAT_W)` for clamping;
  - the preset `PAT_00101 = 5'b00101`.
- One sub-module, `seq_det_hist`, contains the history shift register, the fill counter and the masked compare, and produces `match_next`. The top level holds the configuration registers, the `out` register and the counter.

## Test plan
- Reset release, then load `00101` (len 5, overlap 1). Drive valid stream 1,1,0,0,1,0,1,1,0,0,0,0,0,1,0,1,1,1 -> `out` pulses after bit 7 and after bit 16 only; `match_cnt` = 2.
- Pattern `101`, len 3, stream 1,0,1,0,1 -> overlap 1: pulses after bits 3 and 5 (`match_cnt` = 2); overlap 0: pulse after bit 3 only (`match_cnt` = 1).
- Pattern `00101`, with `in_valid` low for 3 cycles between the 3rd and 4th bits -> single pulse after the 5th valid bit; no pulse during the gap.
- `cfg_load` asserted after 0,0,1,0 of `00101`, reloading the same pattern, then drive 1 -> no pulse (history cleared). The full sequence afterwards matches.
- `cfg_len` = 7 with `PAT_W` = 5 -> behaves as len 5. `cfg_len` = 0 -> no pulse on any stream.
- With `SEQ_DET_CNT_EN`, `CNT_W` = 2: run 4 matches -> `match_cnt` saturates at 3. Assert `cnt_clr` in the same cycle as a match -> 0. Pull `reset_n` low mid-sequence -> `out` = 0, `match_cnt` = 0, `len` = 0.
